// File: rtl/apb_fnd_mux.sv
// APB-controlled multiplexed 7-segment display driver. DATA is shown either as
// hex nibbles or as decimal via a sequential double-dabble converter.
module apb_fnd_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 14,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [3:0]            PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_DIGITS-1:0] fndCom,
  output logic [7:0]            fndFont
);
  localparam int BUF_W  = 4 * NUM_DIGITS;
  localparam int SCAN_W = $clog2(NUM_DIGITS);
  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int EXT_W  = (DATA_W > BUF_W) ? DATA_W : BUF_W;

  function automatic logic [31:0] pow10_minus1(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p - 32'd1;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10_minus1(NUM_DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

  logic [2:0]            r_ctrl;
  logic [BUF_W-1:0]      r_data;
  logic [NUM_DIGITS-1:0] r_dp;
  conv_state_t           r_state;
  logic                  r_ovf;
  logic [DATA_W-1:0]     r_bin;
  logic [BUF_W-1:0]      r_bcd;
  logic [BUF_W-1:0]      r_buf;
  logic [CNT_W-1:0]      r_cnt;
  logic [PRE_W-1:0]      r_presc;
  logic [SCAN_W-1:0]     r_scan;
  logic [NUM_DIGITS-1:0] r_com;
  logic [7:0]            r_font;

  logic              w_access, w_wr, w_wr_ctrl, w_wr_data, w_wr_dp;
  logic              w_start, w_to_hex, w_last, w_src_ovf;
  logic [EXT_W-1:0]  w_src_ext;
  logic [DATA_W-1:0] w_src;
  logic [BUF_W-1:0]  w_bcd_adj, w_bcd_next;
  logic [31:0]       w_rdata;
  logic [3:0]        w_digit;
  logic [SCAN_W-1:0] w_msnz;
  logic              w_blank, w_dp_on;
  logic              w_unused;

  assign w_access  = PSEL & PENABLE & ~PRESET;
  assign w_wr      = w_access & PWRITE;
  assign w_wr_ctrl = w_wr & (PADDR[3:2] == 2'd0);
  assign w_wr_data = w_wr & (PADDR[3:2] == 2'd1);
  assign w_wr_dp   = w_wr & (PADDR[3:2] == 2'd2);

  // A DATA write converts the incoming value, a HEX->decimal switch converts the stored one.
  always_comb begin
    w_src_ext = '0;
    if (w_wr_data) w_src_ext[BUF_W-1:0] = PWDATA[BUF_W-1:0];
    else           w_src_ext[BUF_W-1:0] = r_data;
  end
  assign w_src     = w_src_ext[DATA_W-1:0];
  assign w_src_ovf = ({{(32-DATA_W){1'b0}}, w_src} > MAX_VAL);

  assign w_start  = (w_wr_data & ~r_ctrl[1]) | (w_wr_ctrl & r_ctrl[1] & ~PWDATA[1]);
  assign w_to_hex = w_wr_ctrl & ~r_ctrl[1] & PWDATA[1];
  assign w_last   = (r_state == CONV_RUN) && (r_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end
  assign w_bcd_next = {w_bcd_adj[BUF_W-2:0], r_bin[DATA_W-1]};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_ctrl <= '0;
      r_data <= '0;
      r_dp   <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= PWDATA[2:0];
      if (w_wr_data) r_data <= PWDATA[BUF_W-1:0];
      if (w_wr_dp)   r_dp   <= PWDATA[NUM_DIGITS-1:0];
    end
  end

  // Digits above NUM_DIGITS fall off the top of r_bcd, which yields value mod 10^NUM_DIGITS.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= CONV_IDLE;
      r_ovf   <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
    end else begin
      if (w_start) begin
        r_state <= CONV_RUN;
        r_bin   <= w_src;
        r_bcd   <= '0;
        r_cnt   <= '0;
        r_ovf   <= w_src_ovf;
      end else if (w_to_hex) begin
        r_state <= CONV_IDLE;
        if (r_state == CONV_RUN) r_ovf <= 1'b0;
      end else if (r_state == CONV_RUN) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_state <= CONV_IDLE;
      end
      if (r_ctrl[1])                              r_buf <= r_data;
      else if (w_last && !w_start && !w_to_hex)   r_buf <= w_bcd_next;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_presc <= '0;
      r_scan  <= '0;
    end else if (r_presc == PRE_W'(REFRESH_DIV - 1)) begin
      r_presc <= '0;
      r_scan  <= (r_scan == SCAN_W'(NUM_DIGITS - 1)) ? '0 : r_scan + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_msnz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_buf[4*k +: 4] != 4'd0) w_msnz = SCAN_W'(k);
    end
  end
  assign w_digit = r_buf[4*r_scan +: 4];
  assign w_blank = r_ctrl[2] && (r_scan > w_msnz);
  assign w_dp_on = r_ctrl[0] & r_dp[r_scan];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_com  <= '1;
      r_font <= 8'hFF;
    end else if (r_ctrl[0]) begin
      r_com  <= ~(NUM_DIGITS'(1) << r_scan);
      r_font <= {~w_dp_on, w_blank ? 7'h7F : seg7(w_digit)};
    end else begin
      r_com  <= '1;
      r_font <= 8'hFF;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (PADDR[3:2])
      2'd0:    w_rdata[2:0]            = r_ctrl;
      2'd1:    w_rdata[BUF_W-1:0]      = r_data;
      2'd2:    w_rdata[NUM_DIGITS-1:0] = r_dp;
      default: w_rdata[1:0]            = {r_ovf, r_state == CONV_RUN};
    endcase
  end

  assign PREADY  = w_access;
  assign PRDATA  = w_access ? w_rdata : '0;
  assign fndCom  = r_com;
  assign fndFont = r_font;

  assign w_unused = ^{PADDR[1:0], PWDATA, w_src_ext, w_bcd_adj[BUF_W-1]};
endmodule

// File: tb/tb_apb_fnd_mux.sv
// Randomized scoreboard bench for apb_fnd_mux: APB reads and scanned digits are
// checked against a decimal/hex reference model computed with plain arithmetic.
module tb_apb_fnd_mux;
  localparam int ND = 4;
  localparam int DW = 14;
  localparam int RD = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [3:0]    PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PWDATA, PRDATA;
  logic          PREADY;
  logic [ND-1:0] fndCom;
  logic [7:0]    fndFont;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] exp_q[$];
  logic [11:0] disp_q[$];

  logic [2:0]  m_ctrl;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_ovf;
  int          m_result, busy_until, settle_cyc;

  logic [7:0] font_tbl [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  apb_fnd_mux #(.NUM_DIGITS(ND), .DATA_W(DW), .REFRESH_DIV(RD)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .fndCom(fndCom), .fndFont(fndFont)
  );

  // clock / cycle counter
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // reference model
  task automatic model_reset();
    m_ctrl = '0; m_data = '0; m_dp = '0; m_ovf = 1'b0;
    m_result = 0; busy_until = 0; settle_cyc = 0;
  endtask

  task automatic model_start();
    int v;
    v = int'(m_data[DW-1:0]);
    m_ovf      = (v > 9999);
    m_result   = v % 10000;
    busy_until = cyc + DW;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data);
    logic busy_pre;
    busy_pre = ((cyc - 1) < busy_until);
    case (addr[3:2])
      2'd0: begin
        if (m_ctrl[1] && !data[1]) begin
          m_ctrl = data[2:0];
          model_start();
        end else begin
          if (!m_ctrl[1] && data[1]) begin
            if (busy_pre) m_ovf = 1'b0;
            busy_until = 0;
          end
          m_ctrl = data[2:0];
        end
      end
      2'd1: begin
        m_data = data[15:0];
        if (!m_ctrl[1]) model_start();
      end
      2'd2: m_dp = data[3:0];
      default: ;
    endcase
    settle_cyc = ((busy_until > cyc) ? busy_until : cyc) + 3;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr[3:2])
      2'd0:    return {29'b0, m_ctrl};
      2'd1:    return {16'b0, m_data};
      2'd2:    return {28'b0, m_dp};
      default: return {30'b0, m_ovf, (cyc < busy_until)};
    endcase
  endfunction

  // driver tasks
  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    model_write(addr, data);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr; PWDATA = '0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    exp_q.push_back(model_read(addr));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check_display(input string tag);
    int d[ND];
    int p, msnz, guard;
    logic [3:0] com;
    logic [7:0] f;
    logic [6:0] seg;
    guard = 0;
    while (cyc < settle_cyc && guard < 200) begin @(posedge PCLK); guard++; end
    @(posedge PCLK); #1;
    if (!m_ctrl[0]) begin
      disp_q.push_back({4'hF, 8'hFF});
    end else begin
      p = 1;
      for (int k = 0; k < ND; k++) begin
        if (m_ctrl[1]) d[k] = int'((m_data >> (4 * k)) & 16'hF);
        else           d[k] = (m_result / p) % 10;
        p = p * 10;
      end
      msnz = 0;
      for (int k = 0; k < ND; k++) if (d[k] != 0) msnz = k;
      for (int k = 0; k < ND; k++) begin
        com = ~(4'b0001 << k);
        f   = font_tbl[d[k]];
        seg = (m_ctrl[2] && k > msnz) ? 7'h7F : f[6:0];
        disp_q.push_back({com, ~m_dp[k], seg});
      end
    end
    guard = 0;
    while (disp_q.size() > 0 && guard < 80) begin @(posedge PCLK); guard++; end
    #1;
    if (disp_q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL display_timeout %s: %0d digits not presented, fndCom=%b", tag, disp_q.size(), fndCom);
      disp_q.delete();
    end
  endtask

  task automatic check_scan();
    logic [3:0] prev;
    int n;
    prev = fndCom; n = 0;
    while (fndCom === prev && n < 20) begin @(negedge PCLK); n++; end
    for (int r = 0; r < 5; r++) begin
      prev = fndCom; n = 0;
      while (fndCom === prev && n < 20) begin @(negedge PCLK); n++; end
      check("scan_period", n, RD);
      check("scan_order", {28'b0, fndCom}, {28'b0, prev[2:0], prev[3]});
    end
  endtask

  // scoreboard monitor
  always @(negedge PCLK) begin
    logic [31:0] e;
    logic [11:0] de;
    if (PSEL && PENABLE && !PRESET) begin
      compared++;
      if (PREADY !== 1'b1) begin
        mismatched++;
        $display("FAIL pready: got %b want 1 addr %0h", PREADY, PADDR);
      end
      if (!PWRITE) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL rd_unexpected: read of %0h with empty expected queue", PADDR);
        end else begin
          e = exp_q.pop_front();
          compared++;
          if (PRDATA !== e) begin
            mismatched++;
            $display("FAIL prdata addr %0h: got %0h want %0h (cyc %0d)", PADDR, PRDATA, e, cyc);
          end
        end
      end
    end
    if (disp_q.size() > 0 && fndCom === disp_q[0][11:8]) begin
      de = disp_q.pop_front();
      compared++;
      if (fndFont !== de[7:0]) begin
        mismatched++;
        $display("FAIL font com=%b: got %0h want %0h", fndCom, fndFont, de[7:0]);
      end
    end
  end

  initial begin
    #500000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    int op;
    logic [31:0] wd;
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'hC; PWDATA = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("reset_com", {28'b0, fndCom}, 32'hF);
    check("reset_font", {24'b0, fndFont}, 32'hFF);
    check("reset_pready", {31'b0, PREADY}, 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read(4'h0); apb_read(4'h4); apb_read(4'h8); apb_read(4'hC);

    // all-zero decimal value and scan rotation
    apb_write(4'h0, 32'h1);
    apb_write(4'h4, 32'd0);
    check_display("zero");
    check_scan();

    // 1234: busy window sampled on odd then even offsets
    apb_write(4'h4, 32'd1234);
    repeat (9) apb_read(4'hC);
    check_display("1234a");
    apb_write(4'h4, 32'd1234);
    idle(1);
    repeat (9) apb_read(4'hC);
    check_display("1234b");
    apb_read(4'hC);

    // overflow truncation
    apb_write(4'h4, 32'd12345);
    apb_read(4'hC);
    check_display("12345");
    apb_read(4'hC);

    // leading-zero blanking with DP on a blanked digit
    apb_write(4'h0, 32'h5);
    apb_write(4'h4, 32'd7);
    apb_write(4'h8, 32'h4);
    check_display("lzb7");

    // hex mode, then disable
    apb_write(4'h8, 32'h0);
    apb_write(4'h0, 32'h3);
    apb_write(4'h4, 32'hBEEF);
    apb_read(4'hC);
    check_display("beef");
    apb_write(4'h0, 32'h0);
    check_display("disabled");
    apb_read(4'hC);

    // restart mid-conversion
    apb_write(4'h0, 32'h1);
    apb_write(4'h4, 32'd9999);
    idle(1);
    apb_write(4'h4, 32'd42);
    apb_read(4'hC);
    check_display("restart42");
    apb_read(4'hC);

    // hex switch aborting a conversion
    apb_write(4'h4, 32'd15000);
    apb_read(4'hC);
    apb_write(4'h0, 32'h3);
    apb_read(4'hC);
    check_display("abort_hex");

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: begin
          wd = {$urandom_range(0, 31), 1'b0} & 32'hFFFF_FFF8;
          wd[2] = 1'($urandom_range(0, 1));
          wd[1] = 1'($urandom_range(0, 1));
          wd[0] = ($urandom_range(0, 3) != 0);
          apb_write(4'h0, wd);
        end
        1, 2: begin
          wd = $urandom;
          if ($urandom_range(0, 1) == 1) wd[15:0] = 16'($urandom_range(0, 9999));
          apb_write(4'h4, wd);
        end
        3: apb_write($urandom_range(0, 1) ? 4'h8 : 4'hC, $urandom);
        4: apb_read(4'($urandom_range(0, 3) * 4));
        5: idle($urandom_range(1, 8));
        default: check_display("rand");
      endcase
    end
    check_display("rand_end");

    // reset during a conversion
    apb_write(4'h0, 32'h1);
    apb_write(4'h4, 32'd1234);
    idle(5);
    PRESET = 1'b1;
    idle(2);
    PRESET = 1'b0;
    model_reset();
    apb_read(4'hC);
    apb_write(4'h0, 32'h1);
    check_display("post_reset");
    apb_read(4'h4);

    idle(2);
    if (exp_q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL rd_leftover: %0d expected reads never observed", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
